// File: rtl/mem_stage.sv
// mem_stage: MIPS memory stage; waits for data-SRAM responses, extends/aligns load data, feeds WB and ID forwarding.
// Define MS_UNALIGNED_LD_EN to enable LWL/LWR merging; otherwise load types 5 and 6 behave as LW.
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    output logic        ms_allowin,
    input  logic        es_mem_pending,
    input  logic [2:0]  es_ld_type,
    input  logic [1:0]  es_addr_lo,
    input  logic [31:0] es_rt_value,
    input  logic [31:0] es_result,
    input  logic [4:0]  es_dest,
    input  logic [3:0]  es_gr_we,
    input  logic [31:0] es_pc,
    input  logic [6:0]  es_exc,
    input  logic [42:0] es_misc,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    input  logic        ws_allowin,
    input  logic        flush,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [31:0] ms_final_result,
    output logic [4:0]  ms_dest,
    output logic [3:0]  ms_gr_we,
    output logic [6:0]  ms_exc,
    output logic [42:0] ms_misc,
    output logic [4:0]  fwd_dest,
    output logic [31:0] fwd_data,
    output logic        fwd_blocked
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD, DISCARD} state_t;

    state_t      state, state_next;
    logic        ms_valid, mem_op, ms_ready_go, accept;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic [31:0] result, pc, buffer, word, ld_value;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
`ifdef MS_UNALIGNED_LD_EN
    logic [31:0] rt_value;
`else
    logic        unused_rt;
    assign unused_rt = ^es_rt_value;
`endif

    assign ms_ready_go    = !mem_op || state == HOLD || (state == WAIT && data_ok);
    assign ms_allowin     = (!ms_valid || (ms_ready_go && ws_allowin)) && state != DISCARD;
    assign accept         = es_to_ms_valid && ms_allowin && !flush;
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !flush;

    // A flush never forgets a response that is still on its way.
    always_comb begin
        state_next = state;
        if (flush)
            state_next = ((state == WAIT || state == DISCARD) && !data_ok) ? DISCARD : IDLE;
        else if (accept)
            state_next = es_mem_pending ? WAIT : IDLE;
        else
            case (state)
                WAIT:    state_next = data_ok ? (ws_allowin ? IDLE : HOLD) : WAIT;
                HOLD:    state_next = ws_allowin ? IDLE : HOLD;
                DISCARD: state_next = data_ok ? IDLE : DISCARD;
                default: state_next = IDLE;
            endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ms_valid <= 1'b0;
            mem_op   <= 1'b0;
            ld_type  <= 3'd0;
            addr_lo  <= 2'd0;
            result   <= 32'd0;
            pc       <= RESET_PC;
            buffer   <= 32'd0;
            ms_dest  <= 5'd0;
            ms_gr_we <= 4'd0;
            ms_exc   <= 7'd0;
            ms_misc  <= 43'd0;
`ifdef MS_UNALIGNED_LD_EN
            rt_value <= 32'd0;
`endif
        end else begin
            state <= state_next;
            if (flush)
                ms_valid <= 1'b0;
            else if (ms_allowin)
                ms_valid <= es_to_ms_valid;
            if (accept) begin
                mem_op   <= es_mem_pending;
                ld_type  <= es_ld_type;
                addr_lo  <= es_addr_lo;
                result   <= es_result;
                pc       <= es_pc;
                ms_dest  <= es_dest;
                ms_gr_we <= es_gr_we;
                ms_exc   <= es_exc;
                ms_misc  <= es_misc;
`ifdef MS_UNALIGNED_LD_EN
                rt_value <= es_rt_value;
`endif
            end
            if (state == WAIT && data_ok && !ws_allowin && !flush)
                buffer <= rdata;
        end
    end

    assign word   = state == HOLD ? buffer : rdata;
    assign byte_v = word[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? word[31:16] : word[15:0];

    always_comb begin
        ld_value = word;
        case (ld_type)
            3'd1: ld_value = {{24{byte_v[7]}}, byte_v};
            3'd2: ld_value = {24'd0, byte_v};
            3'd3: ld_value = {{16{half_v[15]}}, half_v};
            3'd4: ld_value = {16'd0, half_v};
`ifdef MS_UNALIGNED_LD_EN
            3'd5: ld_value = addr_lo == 2'd0 ? {word[7:0], rt_value[23:0]} :
                             addr_lo == 2'd1 ? {word[15:0], rt_value[15:0]} :
                             addr_lo == 2'd2 ? {word[23:0], rt_value[7:0]} : word;
            3'd6: ld_value = addr_lo == 2'd0 ? word :
                             addr_lo == 2'd1 ? {rt_value[31:24], word[31:8]} :
                             addr_lo == 2'd2 ? {rt_value[31:16], word[31:16]} :
                                               {rt_value[31:8], word[31:24]};
`endif
            3'd7: ld_value = result;
            default: ld_value = word;
        endcase
    end

    assign ms_final_result = ld_value;
    assign ms_pc           = ms_valid ? pc : RESET_PC;
    assign fwd_data        = ld_value;
    assign fwd_dest        = (ms_valid && |ms_gr_we) ? ms_dest : 5'd0;
    assign fwd_blocked     = ms_valid && ld_type != 3'd7 && !ms_ready_go;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized and directed checks of mem_stage against a byte-lane reference model.
module tb_mem_stage;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic        clk, reset, es_to_ms_valid, ms_allowin, es_mem_pending;
    logic [2:0]  es_ld_type;
    logic [1:0]  es_addr_lo;
    logic [31:0] es_rt_value, es_result, es_pc, rdata, ms_pc, ms_final_result, fwd_data;
    logic [4:0]  es_dest, ms_dest, fwd_dest;
    logic [3:0]  es_gr_we, ms_gr_we;
    logic [6:0]  es_exc, ms_exc;
    logic [42:0] es_misc, ms_misc;
    logic        data_ok, ws_allowin, flush, ms_to_ws_valid, fwd_blocked;
    int          compared = 0;
    int          mismatched = 0;

    mem_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
        .es_mem_pending(es_mem_pending), .es_ld_type(es_ld_type), .es_addr_lo(es_addr_lo),
        .es_rt_value(es_rt_value), .es_result(es_result), .es_dest(es_dest), .es_gr_we(es_gr_we),
        .es_pc(es_pc), .es_exc(es_exc), .es_misc(es_misc), .data_ok(data_ok), .rdata(rdata),
        .ws_allowin(ws_allowin), .flush(flush), .ms_to_ws_valid(ms_to_ws_valid), .ms_pc(ms_pc),
        .ms_final_result(ms_final_result), .ms_dest(ms_dest), .ms_gr_we(ms_gr_we), .ms_exc(ms_exc),
        .ms_misc(ms_misc), .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_blocked(fwd_blocked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Load result computed with shifts and masks on the whole word.
    function automatic logic [31:0] model(input logic [2:0] ld, input logic [1:0] a,
                                          input logic [31:0] rt, input logic [31:0] w,
                                          input logic [31:0] res);
        int sh;
        logic [31:0] b, h;
        sh = 8 * int'(a);
        b = (w >> sh) & 32'h0000_00ff;
        h = (w >> sh) & 32'h0000_ffff;
        case (ld)
            3'd1: return b[7] ? (b | 32'hffff_ff00) : b;
            3'd2: return b;
            3'd3: return h[15] ? (h | 32'hffff_0000) : h;
            3'd4: return h;
`ifdef MS_UNALIGNED_LD_EN
            3'd5: return (w << (24 - sh)) | (rt & ((sh == 24) ? 32'd0 : (32'hffff_ffff >> (sh + 8))));
            3'd6: return (w >> sh) | (rt & ~(32'hffff_ffff >> sh));
`endif
            3'd7: return res;
            default: return w;
        endcase
    endfunction

    task automatic idle_inputs();
        es_to_ms_valid = 1'b0;
        es_mem_pending = 1'b0;
        data_ok        = 1'b0;
        flush          = 1'b0;
        ws_allowin     = 1'b1;
        reset          = 1'b0;
    endtask

    task automatic offer(input logic pending, input logic [2:0] ld, input logic [1:0] a,
                         input logic [31:0] rt, input logic [31:0] res);
        es_to_ms_valid = 1'b1;
        es_mem_pending = pending;
        es_ld_type     = ld;
        es_addr_lo     = a;
        es_rt_value    = rt;
        es_result      = res;
        es_pc          = $urandom;
        es_dest        = 5'($urandom_range(1, 31));
        es_gr_we       = 4'($urandom_range(1, 15));
        es_exc         = 7'($urandom);
        es_misc        = {11'($urandom), 32'($urandom)};
    endtask

    // One memory op: accept, lat WAIT cycles, data_ok, hold cycles of WB back-pressure, then drain.
    task automatic run_load(input logic [2:0] ld, input logic [1:0] a, input logic [31:0] rt,
                            input logic [31:0] w, input logic [31:0] res, input int lat,
                            input int hold, input logic [31:0] exp, input string name);
        logic [31:0] pc;
        logic [4:0]  dest;
        logic [3:0]  we;
        logic [6:0]  exc;
        logic [42:0] misc;
        ws_allowin = 1'b1;
        offer(1'b1, ld, a, rt, res);
        pc = es_pc; dest = es_dest; we = es_gr_we; exc = es_exc; misc = es_misc;
        #1;
        compared++;
        if (ms_allowin !== 1'b1) begin
            mismatched++;
            $display("FAIL %s accept: ms_allowin got %b expected 1", name, ms_allowin);
        end
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        es_result = $urandom; es_rt_value = $urandom; es_addr_lo = 2'($urandom); es_ld_type = 3'($urandom);
        for (int i = 0; i < lat; i++) begin
            #1;
            compared++;
            if ({ms_to_ws_valid, fwd_blocked, fwd_dest, ms_allowin} !== {1'b0, ld != 3'd7, dest, 1'b0}) begin
                mismatched++;
                $display("FAIL %s wait: valid/blocked/fwd_dest/allowin got %b/%b/%0d/%b expected 0/%b/%0d/0",
                         name, ms_to_ws_valid, fwd_blocked, fwd_dest, ms_allowin, ld != 3'd7, dest);
            end
            @(negedge clk);
        end
        data_ok = 1'b1;
        rdata = w;
        ws_allowin = (hold == 0);
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                data_ok = 1'b0;
                rdata = $urandom;
                ws_allowin = (i == hold);
            end
            #1;
            compared++;
            if (ms_to_ws_valid !== 1'b1 || ms_final_result !== exp || fwd_data !== exp) begin
                mismatched++;
                $display("FAIL %s result: valid %b result %h fwd %h expected valid 1 result %h",
                         name, ms_to_ws_valid, ms_final_result, fwd_data, exp);
            end
            if (i < hold) begin
                compared++;
                if (ms_allowin !== 1'b0 || fwd_blocked !== 1'b0) begin
                    mismatched++;
                    $display("FAIL %s hold: allowin %b blocked %b expected 0 0", name, ms_allowin, fwd_blocked);
                end
            end else begin
                compared++;
                if ({ms_pc, ms_dest, ms_gr_we, ms_exc, ms_misc} !== {pc, dest, we, exc, misc}) begin
                    mismatched++;
                    $display("FAIL %s passthrough: pc %h dest %0d we %h exc %h got, expected pc %h dest %0d we %h exc %h",
                             name, ms_pc, ms_dest, ms_gr_we, ms_exc, pc, dest, we, exc);
                end
            end
            @(negedge clk);
        end
        data_ok = 1'b0;
        rdata = $urandom;
        ws_allowin = 1'b1;
        #1;
        compared++;
        if ({ms_to_ws_valid, fwd_dest, ms_pc} !== {1'b0, 5'd0, RESET_PC}) begin
            mismatched++;
            $display("FAIL %s drain: valid %b fwd_dest %0d pc %h expected 0 0 %h",
                     name, ms_to_ws_valid, fwd_dest, ms_pc, RESET_PC);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        compared++;
        if (ms_to_ws_valid !== 1'b0) begin
            mismatched++; $display("FAIL reset valid: got %b expected 0", ms_to_ws_valid);
        end
        compared++;
        if (ms_pc !== RESET_PC) begin
            mismatched++; $display("FAIL reset pc: got %h expected %h", ms_pc, RESET_PC);
        end
        compared++;
        if ({ms_dest, ms_gr_we, ms_exc, ms_misc} !== 59'd0) begin
            mismatched++; $display("FAIL reset regs: dest %0d we %h exc %h misc %h expected 0", ms_dest, ms_gr_we, ms_exc, ms_misc);
        end
        compared++;
        if ({ms_allowin, fwd_dest, fwd_blocked} !== {1'b1, 5'd0, 1'b0}) begin
            mismatched++; $display("FAIL reset fwd: allowin %b fwd_dest %0d blocked %b expected 1 0 0", ms_allowin, fwd_dest, fwd_blocked);
        end
        @(negedge clk);
    endtask

    task automatic test_byte_loads();
        run_load(3'd1, 2'd3, $urandom, 32'h80112233, $urandom, 0, 0, 32'hffffff80, "lb_a3");
        run_load(3'd2, 2'd3, $urandom, 32'h80112233, $urandom, 0, 0, 32'h00000080, "lbu_a3");
        run_load(3'd3, 2'd2, $urandom, 32'h80112233, $urandom, 1, 0, 32'hffff8011, "lh_a2");
        run_load(3'd4, 2'd0, $urandom, 32'h8011a233, $urandom, 1, 1, 32'h0000a233, "lhu_a0");
    endtask

    task automatic test_hold();
        run_load(3'd0, 2'd0, $urandom, 32'hdeadbeef, $urandom, 2, 2, 32'hdeadbeef, "lw_hold");
    endtask

    task automatic test_unaligned();
`ifdef MS_UNALIGNED_LD_EN
        run_load(3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, $urandom, 1, 0, 32'h3344CCDD, "lwl_a1");
        run_load(3'd6, 2'd2, 32'hAABBCCDD, 32'h11223344, $urandom, 1, 1, 32'hAABB1122, "lwr_a2");
`else
        run_load(3'd5, 2'd1, 32'hAABBCCDD, 32'h11223344, $urandom, 1, 0, 32'h11223344, "lwl_a1");
        run_load(3'd6, 2'd2, 32'hAABBCCDD, 32'h11223344, $urandom, 1, 1, 32'h11223344, "lwr_a2");
`endif
    endtask

    task automatic test_flush();
        logic [31:0] res;
        idle_inputs();
        offer(1'b1, 3'd0, 2'd0, $urandom, $urandom);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        flush = 1'b1;
        #1;
        compared++;
        if (ms_to_ws_valid !== 1'b0) begin
            mismatched++; $display("FAIL flush cycle: valid got %b expected 0", ms_to_ws_valid);
        end
        @(negedge clk);
        flush = 1'b0;
        res = $urandom;
        offer(1'b0, 3'd7, 2'd0, $urandom, res);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin data_ok = 1'b1; rdata = $urandom; end
            #1;
            compared++;
            if ({ms_allowin, ms_to_ws_valid, fwd_blocked, fwd_dest} !== {1'b0, 1'b0, 1'b0, 5'd0}) begin
                mismatched++;
                $display("FAIL flush discard %0d: allowin %b valid %b blocked %b fwd_dest %0d expected 0 0 0 0",
                         i, ms_allowin, ms_to_ws_valid, fwd_blocked, fwd_dest);
            end
            @(negedge clk);
        end
        data_ok = 1'b0;
        #1;
        compared++;
        if (ms_allowin !== 1'b1) begin
            mismatched++; $display("FAIL flush reopen: allowin got %b expected 1", ms_allowin);
        end
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        #1;
        compared++;
        if (ms_to_ws_valid !== 1'b1 || ms_final_result !== res) begin
            mismatched++; $display("FAIL flush next op: valid %b result %h expected 1 %h", ms_to_ws_valid, ms_final_result, res);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [31:0] pres;
        logic [4:0]  pdest;
        logic [3:0]  pwe;
        idle_inputs();
        pres = 0; pdest = 0; pwe = 0;
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) begin
                offer(1'b0, 3'd7, 2'($urandom), $urandom, $urandom);
                es_gr_we = 4'($urandom_range(0, 15));
            end else
                es_to_ms_valid = 1'b0;
            #1;
            if (k > 0) begin
                compared++;
                if ({ms_to_ws_valid, ms_final_result, fwd_dest, fwd_blocked, ms_allowin} !==
                    {1'b1, pres, (|pwe ? pdest : 5'd0), 1'b0, 1'b1}) begin
                    mismatched++;
                    $display("FAIL b2b %0d: valid %b result %h fwd_dest %0d blocked %b allowin %b expected 1 %h %0d 0 1",
                             k, ms_to_ws_valid, ms_final_result, fwd_dest, fwd_blocked, ms_allowin,
                             pres, (|pwe ? pdest : 5'd0));
                end
            end
            pres = es_result; pdest = es_dest; pwe = es_gr_we;
            @(negedge clk);
        end
        #1;
        compared++;
        if (ms_to_ws_valid !== 1'b0) begin
            mismatched++; $display("FAIL b2b drain: valid got %b expected 0", ms_to_ws_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        offer(1'b1, 3'd0, 2'd0, $urandom, $urandom);
        @(negedge clk);
        es_to_ms_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        compared++;
        if ({ms_to_ws_valid, ms_pc, ms_allowin, fwd_blocked, fwd_dest} !== {1'b0, RESET_PC, 1'b1, 1'b0, 5'd0}) begin
            mismatched++;
            $display("FAIL reset mid wait: valid %b pc %h allowin %b blocked %b fwd_dest %0d expected 0 %h 1 0 0",
                     ms_to_ws_valid, ms_pc, ms_allowin, fwd_blocked, fwd_dest, RESET_PC);
        end
        @(negedge clk);
        data_ok = 1'b1;
        rdata = $urandom;
        #1;
        compared++;
        if ({ms_to_ws_valid, ms_allowin} !== 2'b01) begin
            mismatched++; $display("FAIL stray data_ok: valid %b allowin %b expected 0 1", ms_to_ws_valid, ms_allowin);
        end
        @(negedge clk);
        data_ok = 1'b0;
        run_load(3'd0, 2'd0, $urandom, 32'h0badcafe, $urandom, 1, 0, 32'h0badcafe, "lw_after_reset");
    endtask

    task automatic test_random();
        logic [2:0]  ld;
        logic [1:0]  a;
        logic [31:0] rt, w, res;
        for (int n = 0; n < 40; n++) begin
            ld = 3'($urandom_range(0, 7));
            a = 2'($urandom);
            if (ld == 3'd3 || ld == 3'd4) a[0] = 1'b0;
            rt = $urandom; w = $urandom; res = $urandom;
            run_load(ld, a, rt, w, res, $urandom_range(0, 3), $urandom_range(0, 2),
                     model(ld, a, rt, w, res), $sformatf("rand%0d_t%0d_a%0d", n, ld, a));
        end
    endtask

    initial begin
        es_ld_type = 3'd7; es_addr_lo = 2'd0; es_rt_value = 0; es_result = 0; es_dest = 0;
        es_gr_we = 0; es_pc = 0; es_exc = 0; es_misc = 0; rdata = 0;
        test_reset();
        test_byte_loads();
        test_hold();
        test_flush();
        test_back_to_back();
        test_unaligned();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
